// File: rtl/vx_fpu_tracker_pkg.sv
// Shared FPU definitions used by the FPU request tracker and its bus interface.
package vx_fpu_tracker_pkg;

    localparam int unsigned NUM_THREADS   = 4;
    localparam int unsigned INST_FPU_BITS = 4;
    localparam int unsigned INST_MOD_BITS = 3;
    localparam int unsigned FFLAGS_W      = 5;

    // RISC-V accrued exception flags, MSB first: NV DZ OF UF NX
    typedef struct packed {
        logic nv;
        logic dz;
        logic ovf;
        logic unf;
        logic nx;
    } fflags_t;

endpackage

// File: rtl/vx_fpu_tracker_if.sv
// Bundle of upstream request, FPU issue/return, commit and status signals of the tracker.
interface vx_fpu_tracker_if
    import vx_fpu_tracker_pkg::*;
#(
    parameter int unsigned TAGW   = 4,
    parameter int unsigned META_W = 32
) ();

    // upstream request
    logic                          req_valid;
    logic                          req_ready;
    logic [META_W-1:0]             req_meta;
    logic [NUM_THREADS-1:0]        req_tmask;
    logic [INST_FPU_BITS-1:0]      req_op_type;
    logic [INST_MOD_BITS-1:0]      req_frm;
    logic [NUM_THREADS*32-1:0]     req_dataa;
    logic [NUM_THREADS*32-1:0]     req_datab;
    logic [NUM_THREADS*32-1:0]     req_datac;

    // FPU issue
    logic                          fpu_valid_in;
    logic                          fpu_ready_in;
    logic [TAGW-1:0]               fpu_tag_in;
    logic [INST_FPU_BITS-1:0]      fpu_op_type;
    logic [INST_MOD_BITS-1:0]      fpu_frm;
    logic [NUM_THREADS*32-1:0]     fpu_dataa;
    logic [NUM_THREADS*32-1:0]     fpu_datab;
    logic [NUM_THREADS*32-1:0]     fpu_datac;

    // FPU return
    logic                          fpu_valid_out;
    logic                          fpu_ready_out;
    logic [TAGW-1:0]               fpu_tag_out;
    logic [NUM_THREADS*32-1:0]     fpu_result;
    logic                          fpu_has_fflags;
    fflags_t [NUM_THREADS-1:0]     fpu_fflags;

    // commit
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [META_W-1:0]             rsp_meta;
    logic [NUM_THREADS-1:0]        rsp_tmask;
    logic [NUM_THREADS*32-1:0]     rsp_result;
    logic                          rsp_has_fflags;
    fflags_t                       rsp_fflags;

    // status
    logic [TAGW:0]                 pending;
    logic                          empty;

    // tracker side
    modport slave (
        input  req_valid, req_meta, req_tmask, req_op_type, req_frm,
               req_dataa, req_datab, req_datac,
        output req_ready,
        output fpu_valid_in, fpu_tag_in, fpu_op_type, fpu_frm,
               fpu_dataa, fpu_datab, fpu_datac,
        input  fpu_ready_in,
        input  fpu_valid_out, fpu_tag_out, fpu_result, fpu_has_fflags, fpu_fflags,
        output fpu_ready_out,
        output rsp_valid, rsp_meta, rsp_tmask, rsp_result, rsp_has_fflags, rsp_fflags,
        input  rsp_ready,
        output pending, empty
    );

    // environment side
    modport master (
        output req_valid, req_meta, req_tmask, req_op_type, req_frm,
               req_dataa, req_datab, req_datac,
        input  req_ready,
        input  fpu_valid_in, fpu_tag_in, fpu_op_type, fpu_frm,
               fpu_dataa, fpu_datab, fpu_datac,
        output fpu_ready_in,
        output fpu_valid_out, fpu_tag_out, fpu_result, fpu_has_fflags, fpu_fflags,
        input  fpu_ready_out,
        input  rsp_valid, rsp_meta, rsp_tmask, rsp_result, rsp_has_fflags, rsp_fflags,
        output rsp_ready,
        input  pending, empty
    );

endinterface

// File: rtl/vx_priority_encoder.sv
// Returns the index of the lowest set request bit, plus a flag telling whether any bit is set.
module vx_priority_encoder #(
    parameter int unsigned N = 16,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // scan from the top down so the lowest set bit is written last
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_fpu_tracker.sv
// Tags FPU requests, remembers their metadata until the result comes back in any order,
// and presents each result with its metadata through a single registered commit stage.
module vx_fpu_tracker
    import vx_fpu_tracker_pkg::*;
#(
    parameter int unsigned TAGW   = 4,
    parameter int unsigned META_W = 32
) (
    input logic             clk,
    input logic             reset,
    vx_fpu_tracker_if.slave bus
);

    localparam int unsigned DEPTH = 32'(1) << TAGW;
    localparam int unsigned PW    = TAGW + 1;

    logic [DEPTH-1:0]        busy;
    logic [META_W-1:0]       meta_tbl  [DEPTH];
    logic [NUM_THREADS-1:0]  tmask_tbl [DEPTH];
    logic [PW-1:0]           pending_q;

    logic                    rsp_valid_q;
    logic [META_W-1:0]       rsp_meta_q;
    logic [NUM_THREADS-1:0]  rsp_tmask_q;
    logic [NUM_THREADS*32-1:0] rsp_result_q;
    logic                    rsp_has_fflags_q;
    fflags_t                 rsp_fflags_q;

    logic [TAGW-1:0]         free_tag;
    logic                    free_any;
    logic                    full;
    logic                    can_issue;
    logic                    issue_fire;
    logic                    ret_fire;
    logic [FFLAGS_W-1:0]     merged_fflags;

    // lowest free tag, taken from the busy bits as they stand at the start of the cycle
    vx_priority_encoder #(
        .N (DEPTH)
    ) u_free_tag (
        .req   (~busy),
        .idx   (free_tag),
        .valid (free_any)
    );

    assign full       = (pending_q == PW'(DEPTH));
    // busy bits and the counter always agree; free_any is the same condition seen from the table
    assign can_issue  = !full && free_any;

    assign bus.fpu_valid_in = bus.req_valid && can_issue;
    assign bus.req_ready    = bus.fpu_ready_in && can_issue;
    assign bus.fpu_tag_in   = free_tag;
    assign bus.fpu_op_type  = bus.req_op_type;
    assign bus.fpu_frm      = bus.req_frm;
    assign bus.fpu_dataa    = bus.req_dataa;
    assign bus.fpu_datab    = bus.req_datab;
    assign bus.fpu_datac    = bus.req_datac;

    assign issue_fire = bus.req_valid && bus.req_ready;

    // accept a return whenever the commit stage is empty or draining this cycle
    assign bus.fpu_ready_out = !rsp_valid_q || bus.rsp_ready;
    assign ret_fire          = bus.fpu_valid_out && bus.fpu_ready_out;

    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_meta       = rsp_meta_q;
    assign bus.rsp_tmask      = rsp_tmask_q;
    assign bus.rsp_result     = rsp_result_q;
    assign bus.rsp_has_fflags = rsp_has_fflags_q;
    assign bus.rsp_fflags     = rsp_fflags_q;
    assign bus.pending        = pending_q;
    assign bus.empty          = (pending_q == '0);

    // OR the exception flags of the lanes that were active when the request was issued
    always_comb begin
        merged_fflags = '0;
        for (int l = 0; l < NUM_THREADS; l++) begin
            if (tmask_tbl[bus.fpu_tag_out][l]) begin
                merged_fflags = merged_fflags | bus.fpu_fflags[l];
            end
        end
        if (!bus.fpu_has_fflags) begin
            merged_fflags = '0;
        end
    end

    // control state: busy bits, outstanding count and commit-stage valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= '0;
            pending_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (issue_fire) begin
                busy[free_tag] <= 1'b1;
            end
            if (ret_fire) begin
                busy[bus.fpu_tag_out] <= 1'b0;
            end
            if (issue_fire && !ret_fire) begin
                pending_q <= pending_q + PW'(1);
            end else if (!issue_fire && ret_fire) begin
                pending_q <= pending_q - PW'(1);
            end
            if (ret_fire) begin
                rsp_valid_q <= 1'b1;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // payload storage: per-tag table on issue, commit stage on return
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            meta_tbl[free_tag]  <= bus.req_meta;
            tmask_tbl[free_tag] <= bus.req_tmask;
        end
        if (ret_fire) begin
            rsp_meta_q       <= meta_tbl[bus.fpu_tag_out];
            rsp_tmask_q      <= tmask_tbl[bus.fpu_tag_out];
            rsp_result_q     <= bus.fpu_result;
            rsp_has_fflags_q <= bus.fpu_has_fflags;
            rsp_fflags_q     <= fflags_t'(merged_fflags);
        end
    end

`ifndef SYNTHESIS
    // a returned tag must belong to an outstanding request
    ret_tag_busy: assert property (@(posedge clk) disable iff (reset)
        ret_fire |-> busy[bus.fpu_tag_out]);
`endif

endmodule

// File: tb/tb_vx_fpu_tracker.sv
// Randomized and directed bench for vx_fpu_tracker against a tag-pool / response-queue model.
module tb_vx_fpu_tracker;
    import vx_fpu_tracker_pkg::*;

    localparam int unsigned TAGW  = 4;
    localparam int          DEPTH = 16;

    logic clk;
    logic reset;

    vx_fpu_tracker_if #(.TAGW(TAGW), .META_W(32)) bus ();

    vx_fpu_tracker #(.TAGW(TAGW), .META_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  meta;
        logic [3:0]   tmask;
        logic [127:0] result;
        logic         has;
        logic [4:0]   ff;
    } rsp_t;

    // model: outstanding requests keyed by tag, and results waiting to be committed
    logic [31:0] out_meta  [int];
    logic [3:0]  out_tmask [int];
    rsp_t        rsp_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int lowest_free();
        for (int t = 0; t < DEPTH; t++) if (!out_meta.exists(t)) return t;
        return -1;
    endfunction

    function automatic int lowest_busy();
        for (int t = 0; t < DEPTH; t++) if (out_meta.exists(t)) return t;
        return -1;
    endfunction

    function automatic int random_busy();
        int keys[$];
        foreach (out_meta[k]) keys.push_back(k);
        return keys[$urandom_range(0, keys.size() - 1)];
    endfunction

    task automatic drive_idle();
        bus.req_valid = 1'b0; bus.req_meta = '0; bus.req_tmask = '0;
        bus.req_op_type = '0; bus.req_frm = '0;
        bus.req_dataa = '0; bus.req_datab = '0; bus.req_datac = '0;
        bus.fpu_ready_in = 1'b0; bus.fpu_valid_out = 1'b0; bus.fpu_tag_out = '0;
        bus.fpu_result = '0; bus.fpu_has_fflags = 1'b0; bus.fpu_fflags = '0;
        bus.rsp_ready = 1'b0;
    endtask

    // one clock cycle: drive, check against the model, then advance the model at the edge
    task automatic cycle(input logic rv, input logic [31:0] meta, input logic [3:0] tm,
                         input logic fir, input logic fvo, input int rtag,
                         input logic has, input logic [19:0] ff, input logic rr);
        int           cnt, itag;
        logic         can_issue, issue, ret;
        logic [127:0] res, da;
        logic [3:0]   op;
        logic [4:0]   ef;
        rsp_t         r;
        @(negedge clk);
        res = rnd128();
        da  = rnd128();
        op  = 4'($urandom());
        bus.req_valid = rv; bus.req_meta = meta; bus.req_tmask = tm;
        bus.req_op_type = op; bus.req_frm = 3'($urandom());
        bus.req_dataa = da; bus.req_datab = rnd128(); bus.req_datac = rnd128();
        bus.fpu_ready_in = fir; bus.fpu_valid_out = fvo; bus.fpu_tag_out = 4'(rtag);
        bus.fpu_result = res; bus.fpu_has_fflags = has; bus.fpu_fflags = ff;
        bus.rsp_ready = rr;
        #1;
        cnt       = out_meta.num();
        can_issue = (cnt < DEPTH);
        itag      = lowest_free();
        chk("pending", 128'(bus.pending), 128'(cnt));
        chk("empty", 128'(bus.empty), 128'(cnt == 0));
        chk("req_ready", 128'(bus.req_ready), 128'(fir && can_issue));
        chk("fpu_valid_in", 128'(bus.fpu_valid_in), 128'(rv && can_issue));
        if (can_issue) chk("fpu_tag_in", 128'(bus.fpu_tag_in), 128'(itag));
        chk("fpu_dataa", bus.fpu_dataa, da);
        chk("fpu_op_type", 128'(bus.fpu_op_type), 128'(op));
        chk("fpu_ready_out", 128'(bus.fpu_ready_out), 128'(rsp_q.size() == 0 || rr));
        chk("rsp_valid", 128'(bus.rsp_valid), 128'(rsp_q.size() != 0));
        if (rsp_q.size() != 0) begin
            chk("rsp_meta", 128'(bus.rsp_meta), 128'(rsp_q[0].meta));
            chk("rsp_tmask", 128'(bus.rsp_tmask), 128'(rsp_q[0].tmask));
            chk("rsp_result", bus.rsp_result, rsp_q[0].result);
            chk("rsp_has_fflags", 128'(bus.rsp_has_fflags), 128'(rsp_q[0].has));
            chk("rsp_fflags", 128'(bus.rsp_fflags), 128'(rsp_q[0].ff));
        end
        issue = rv && can_issue && fir;
        ret   = fvo && (rsp_q.size() == 0 || rr);
        @(posedge clk);
        if (rsp_q.size() != 0 && rr) void'(rsp_q.pop_front());
        if (ret) begin
            ef = '0;
            if (has) for (int l = 0; l < 4; l++) if (out_tmask[rtag][l]) ef = ef | ff[l*5 +: 5];
            r.meta = out_meta[rtag]; r.tmask = out_tmask[rtag];
            r.result = res; r.has = has; r.ff = ef;
            rsp_q.push_back(r);
            out_meta.delete(rtag);
            out_tmask.delete(rtag);
        end
        if (issue) begin
            out_meta[itag]  = meta;
            out_tmask[itag] = tm;
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 0, 1'b0, '0, rr);
    endtask

    task automatic issue_one(input logic [31:0] meta, input logic [3:0] tm);
        cycle(1'b1, meta, tm, 1'b1, 1'b0, 0, 1'b0, '0, 1'b1);
    endtask

    task automatic ret_one(input int tag, input logic rr);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, tag, 1'b0, '0, rr);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && out_meta.num() != 0; i++) ret_one(lowest_busy(), 1'b1);
        idle(1'b1);
        idle(1'b1);
    endtask

    task automatic random_phase(input int ncyc, input int p_ret);
        logic fvo;
        int   tag;
        for (int i = 0; i < ncyc; i++) begin
            fvo = (out_meta.num() != 0) && ($urandom_range(0, 99) < p_ret);
            tag = fvo ? random_busy() : 0;
            cycle($urandom_range(0, 99) < 60, $urandom(), 4'($urandom()),
                  $urandom_range(0, 99) < 75, fvo, tag,
                  1'($urandom()), 20'($urandom()), $urandom_range(0, 99) < 70);
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pending", 128'(bus.pending), 128'(0));
        chk("reset_empty", 128'(bus.empty), 128'(1));
        chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        reset = 1'b0;
        idle(1'b1);

        // single issue, return three cycles later, commit one cycle after that
        issue_one(32'hA0D0_0001, 4'hF);
        repeat (3) idle(1'b1);
        ret_one(0, 1'b1);
        #1;
        chk("single_rsp_meta", 128'(bus.rsp_meta), 128'(32'hA0D0_0001));
        idle(1'b1);

        // fill every tag, try one more, free tag 5 and reuse it
        for (int i = 0; i < DEPTH; i++) issue_one(32'h1000 + 32'(i), 4'($urandom()));
        cycle(1'b1, 32'hDEAD, 4'hF, 1'b1, 1'b0, 0, 1'b0, '0, 1'b1);
        cycle(1'b1, 32'hBEEF, 4'hF, 1'b1, 1'b1, 5, 1'b0, '0, 1'b1);
        issue_one(32'h5555, 4'h3);
        #1;
        chk("reuse_tag5_full", 128'(bus.pending), 128'(DEPTH));
        // return tag 0 while full, then simultaneous issue and return of tag 7
        cycle(1'b1, 32'hC0DE, 4'hF, 1'b1, 1'b1, 0, 1'b0, '0, 1'b1);
        cycle(1'b1, 32'hF00D, 4'hF, 1'b1, 1'b1, 7, 1'b0, '0, 1'b1);
        drain();

        // out-of-order returns
        for (int i = 0; i < 4; i++) issue_one(32'h2000 + 32'(i), 4'hF);
        ret_one(3, 1'b1);
        ret_one(1, 1'b1);
        ret_one(2, 1'b1);
        ret_one(0, 1'b1);
        drain();

        // lane-merged fflags: lanes 0 and 2 active, NV on lane 1, OF on lane 2
        issue_one(32'h3000, 4'b0101);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 0, 1'b1, {5'b0, 5'b00100, 5'b10000, 5'b0}, 1'b1);
        #1;
        chk("fflags_of_only", 128'(bus.rsp_fflags), 128'(5'b00100));
        issue_one(32'h3001, 4'b0101);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 0, 1'b0, {5'b0, 5'b00100, 5'b10000, 5'b0}, 1'b1);
        #1;
        chk("fflags_no_has", 128'(bus.rsp_fflags), 128'(0));
        drain();

        // commit backpressure with a second return waiting
        issue_one(32'h4000, 4'h1);
        issue_one(32'h4001, 4'h2);
        ret_one(0, 1'b0);
        for (int i = 0; i < 5; i++) ret_one(1, 1'b0);
        ret_one(1, 1'b1);
        drain();

        // asynchronous reset with four outstanding and a result held
        for (int i = 0; i < 5; i++) issue_one(32'h6000 + 32'(i), 4'hF);
        ret_one(2, 1'b0);
        @(negedge clk);
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pending", 128'(bus.pending), 128'(0));
        chk("async_rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("async_rst_empty", 128'(bus.empty), 128'(1));
        out_meta.delete();
        out_tmask.delete();
        rsp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1);

        // random traffic: mostly filling, then mostly draining
        random_phase(700, 25);
        random_phase(700, 70);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
